load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sequencer between the multicycle RISC-V control/datapath and MemoryInterface.
//  Accepts one load/store request at a time and handles RV32I byte/half/word sizing:
//  - loads: lane extraction plus sign/zero extension;
//  - sub-word stores: read-modify-write, because the data RAM has no byte enables;
//  - rejects misaligned accesses, illegal funct3, and stores to instruction space (addr[28]=0).
// PARAMETERS
//  RD_LAT   1   cycles from the oMemRead cycle until iMemRData is valid (1..4)
// PORTS
//  iCLK        in   1   single clock, all state on rising edge
//  iRSTn       in   1   synchronous, active-low reset
//  iReq        in   1   request strobe, sampled only in IDLE
//  iWe         in   1   1=store, 0=load
//  iFunct3     in   3   RV32I funct3 of the load/store
//  iAddr       in   32  byte address
//  iWData      in   32  store data (rs2), low bits used for SB/SH
//  oBusy       out  1   high in every state except IDLE
//  oDone       out  1   one-cycle completion pulse
//  oFault      out  1   valid with oDone: request rejected, no memory write performed
//  oRData      out  32  extended load result, held until the next accepted request
//  oMemAddr    out  32  word-aligned address to MemoryInterface ({addr[31:2],2'b00})
//  oMemRead    out  1   read strobe
//  oMemWrite   out  1   write strobe
//  oMemWData   out  32  write word
//  iMemRData   in   32  read word from MemoryInterface
// BEHAVIOUR
//  Reset (iRSTn=0 at an edge): state=IDLE; every output is 0, including oRData.
//  Reset mid-operation aborts the operation. No strobe appears in the cycle after the reset edge.
//  Accept: in IDLE with iReq=1, register iWe, iFunct3, iAddr and iWData; oBusy=1 next cycle.
//  iReq is ignored while oBusy=1 (not queued).
//  Legal funct3:
//  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
//  - stores: 000 SB, 001 SH, 010 SW.
//  Fault conditions: any other funct3; LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0;
//  or a store with addr[28]=0.
//  On fault: IDLE->DONE, oFault=1, no strobe, oRData unchanged.
//  FSM states: IDLE, READ, WAIT, WRITE, DONE.
//  - IDLE->READ: accepted load or SB/SH.
//  - IDLE->WRITE: accepted SW.
//  - IDLE->DONE: fault.
//  - READ: oMemRead=1 for exactly 1 cycle. READ->WAIT.
//  - WAIT: lasts RD_LAT cycles (down-counter). iMemRData is captured on the last cycle.
//    Then WAIT->DONE for a load, WAIT->WRITE for SB/SH.
//  - WRITE: oMemWrite=1 for exactly 1 cycle, oMemWData = merged word (SB/SH) or iWData (SW).
//    WRITE->DONE.
//  - DONE: oDone=1 for 1 cycle. DONE->IDLE.
//  Strobes: oMemRead and oMemWrite are never high together. oMemAddr is stable from
//  READ/WRITE entry through DONE.
//  Latency in cycles after the request cycle (RD_LAT=1): load oDone at +3, SW at +2,
//  SB/SH at +4, fault at +1. Loads and RMW stores add RD_LAT-1 cycles.
//  Lanes are little-endian:
//  - SB/LB/LBU use byte addr[1:0];
//  - SH/LH/LHU use half addr[1];
//  - merge replaces only the addressed lane of the captured word.
//  Extension: LB/LH sign-extend the lane MSB to 32 bits; LBU/LHU zero-extend; LW passes through.
//  oRData updates only on a successful load.
//  Loads from instruction space (addr[28]=0) are legal.
// STRUCTURE
//  lsu_defs.vh: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encodings,
//  and the region bit index (REGION_BIT=28).
//  Sub-module lsu_align (combinational) holds the lane extract/extend and lane merge functions.
//  The FSM, capture registers and counter stay in the top.
// TESTING
//  1. LW addr 0x1000_0004, iMemRData=0xDEAD_BEEF -> one oMemRead at +1, oDone at +3,
//     oRData=0xDEAD_BEEF, oFault=0.
//  2. LB 0x1000_0003 on 0x80FF_FFFF -> oRData=0xFFFF_FF80; LBU same -> 0x0000_0080;
//     LHU 0x1000_0002 -> 0x0000_80FF.
//  3. SB 0x1000_0001 data 0xAB on stored 0x1122_3344 -> read at +1, write at +3 with
//     oMemWData=0x1122_AB44, oDone at +4.
//  4. SW 0x0000_0010 (instruction space) -> oDone+oFault at +1, no strobe.
//     LH 0x1000_0001 -> fault.
//  5. RD_LAT=3, LW -> oDone at +5. A second iReq pulsed mid-operation is ignored.
//  6. iRSTn=0 during WAIT of an SH -> next cycle IDLE, all outputs 0, no oMemWrite ever issued.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes,
// the instruction/data region bit, FSM states and the fault check.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // addr[REGION_BIT]=0 is instruction space, which may be read but never written
    localparam int REGION_BIT = 28;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } lsu_state_e;

    // True when a request must be rejected without touching memory
    function automatic logic is_fault(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] byte_off,
                                      input logic       region);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = byte_off[0];
            F3_W:    bad = |byte_off;
            F3_BU:   bad = we;
            F3_HU:   bad = we | byte_off[0];
            default: bad = 1'b1;
        endcase
        if (we && !region) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane handling for the load/store unit: extracts and extends the addressed
// lane of a loaded word, and merges store data into a previously read word.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] load_word,
    input  logic [31:0] merge_word,
    input  logic [15:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the little-endian byte/half lane and extend it by funct3
    always_comb begin
        case (byte_off)
            2'd0:    lane_b = load_word[7:0];
            2'd1:    lane_b = load_word[15:8];
            2'd2:    lane_b = load_word[23:16];
            default: lane_b = load_word[31:24];
        endcase
        lane_h = byte_off[1] ? load_word[31:16] : load_word[15:0];
        case (funct3)
            F3_B:    load_value = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_value = {{16{lane_h[15]}}, lane_h};
            F3_BU:   load_value = {24'h0, lane_b};
            F3_HU:   load_value = {16'h0, lane_h};
            default: load_value = load_word;
        endcase
    end

    // Replace only the addressed lane of the read word for SB/SH
    always_comb begin
        merged_word = merge_word;
        if (funct3 == F3_H) begin
            if (byte_off[1]) merged_word[31:16] = store_data;
            else             merged_word[15:0]  = store_data;
        end else begin
            case (byte_off)
                2'd0:    merged_word[7:0]   = store_data[7:0];
                2'd1:    merged_word[15:8]  = store_data[7:0];
                2'd2:    merged_word[23:16] = store_data[7:0];
                default: merged_word[31:24] = store_data[7:0];
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the multicycle core and MemoryInterface.
// One request at a time; sub-word stores are done as read-modify-write
// because the data RAM has no byte enables.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iReq,
    input  logic        iWe,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    output logic        oBusy,
    output logic        oDone,
    output logic        oFault,
    output logic [31:0] oRData,
    output logic [31:0] oMemAddr,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic [31:0] oMemWData,
    input  logic [31:0] iMemRData
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    lsu_state_e  state, state_next;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_word_q;
    logic [31:0] mem_addr_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic [1:0]  cnt;
    logic        accept_fault;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    assign accept_fault = is_fault(iWe, iFunct3, iAddr[1:0], iAddr[REGION_BIT]);
    assign oRData       = rdata_q;
    assign oMemAddr     = mem_addr_q;

    load_store_unit_align u_align (
        .funct3      (f3_q),
        .byte_off    (off_q),
        .load_word   (iMemRData),
        .merge_word  (rd_word_q),
        .store_data  (wdata_q[15:0]),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    // State register; reset aborts any operation in flight
    always_ff @(posedge iCLK) begin
        if (!iRSTn) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and the per-state strobes
    always_comb begin
        state_next = state;
        oBusy      = 1'b1;
        oDone      = 1'b0;
        oFault     = 1'b0;
        oMemRead   = 1'b0;
        oMemWrite  = 1'b0;
        oMemWData  = 32'h0;
        case (state)
            S_IDLE: begin
                oBusy = 1'b0;
                if (iReq) begin
                    if (accept_fault)                     state_next = S_DONE;
                    else if (iWe && (iFunct3 == F3_W))    state_next = S_WRITE;
                    else                                  state_next = S_READ;
                end
            end
            S_READ: begin
                oMemRead   = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 2'd0) state_next = we_q ? S_WRITE : S_DONE;
            end
            S_WRITE: begin
                oMemWrite  = 1'b1;
                oMemWData  = (f3_q == F3_W) ? wdata_q : merged_word;
                state_next = S_DONE;
            end
            S_DONE: begin
                oDone      = 1'b1;
                oFault     = fault_q;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request capture, read-latency counter and read-data capture
    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            wdata_q    <= 32'h0;
            rd_word_q  <= 32'h0;
            mem_addr_q <= 32'h0;
            rdata_q    <= 32'h0;
            fault_q    <= 1'b0;
            cnt        <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iReq) begin
                        we_q       <= iWe;
                        f3_q       <= iFunct3;
                        off_q      <= iAddr[1:0];
                        wdata_q    <= iWData;
                        mem_addr_q <= {iAddr[31:2], 2'b00};
                        fault_q    <= accept_fault;
                    end
                end
                S_READ: cnt <= LAT_INIT;
                S_WAIT: begin
                    if (cnt == 2'd0) begin
                        if (we_q) rd_word_q <= iMemRData;
                        else      rdata_q   <= load_value;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a vector table run through a
// scoreboard on an RD_LAT=1 instance, plus hand sequences for RD_LAT=3 and
// reset during an in-flight read-modify-write.
module tb_load_store_unit;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic        fault;
        logic [31:0] rdata;
        int          rd_cyc;
        int          wr_cyc;
        int          done_cyc;
        logic [31:0] wr_data;
    } vec_t;

    logic iCLK = 1'b0;
    logic iRSTn;
    always #5 iCLK = ~iCLK;

    logic        req1, we1;
    logic [2:0]  f3_1;
    logic [31:0] addr1, wdata1;
    logic        busy1, done1, fault1, mrd1, mwr1;
    logic [31:0] rdata1, maddr1, mwdata1, mrdata1;
    logic [31:0] mem_word1;
    logic        pipe1 = 1'b0;

    logic        req3, we3;
    logic [2:0]  f3_3;
    logic [31:0] addr3, wdata3;
    logic        busy3, done3, fault3, mrd3, mwr3;
    logic [31:0] rdata3, maddr3, mwdata3, mrdata3;
    logic [31:0] mem_word3;
    logic [2:0]  pipe3 = 3'b000;

    load_store_unit #(.RD_LAT(1)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iReq(req1), .iWe(we1), .iFunct3(f3_1),
        .iAddr(addr1), .iWData(wdata1), .oBusy(busy1), .oDone(done1),
        .oFault(fault1), .oRData(rdata1), .oMemAddr(maddr1), .oMemRead(mrd1),
        .oMemWrite(mwr1), .oMemWData(mwdata1), .iMemRData(mrdata1)
    );

    load_store_unit #(.RD_LAT(3)) dut3 (
        .iCLK(iCLK), .iRSTn(iRSTn), .iReq(req3), .iWe(we3), .iFunct3(f3_3),
        .iAddr(addr3), .iWData(wdata3), .oBusy(busy3), .oDone(done3),
        .oFault(fault3), .oRData(rdata3), .oMemAddr(maddr3), .oMemRead(mrd3),
        .oMemWrite(mwr3), .oMemWData(mwdata3), .iMemRData(mrdata3)
    );

    // Memory model: read data is valid only exactly RD_LAT cycles after the read strobe
    always @(posedge iCLK) begin
        pipe1 <= mrd1;
        pipe3 <= {pipe3[1:0], mrd3};
    end
    assign mrdata1 = pipe1    ? mem_word1 : 32'h0BAD_0BAD;
    assign mrdata3 = pipe3[2] ? mem_word3 : 32'h0BAD_0BAD;

    int          n_vec = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_rdata = 32'h0;
    vec_t        sb_q[$];
    vec_t        vecs[18];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge iCLK);
        #1;
        req1      = 1'b1;
        we1       = v.we;
        f3_1      = v.f3;
        addr1     = v.addr;
        wdata1    = v.wdata;
        mem_word1 = v.mem;
        sb_q.push_back(v);
        n_vec++;
    endtask

    task automatic checkOutput(input int idx);
        vec_t        e;
        int          rdc, wrc, dc, rdn, wrn, ovl;
        logic        flt, busy_first, busy_after;
        logic [31:0] wd, ad, rd;
        e = sb_q.pop_front();
        rdc = 0; wrc = 0; dc = 0; rdn = 0; wrn = 0; ovl = 0;
        flt = 1'b0; busy_first = 1'b0; busy_after = 1'b1;
        wd = 32'h0; ad = 32'h0; rd = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge iCLK);
            #1;
            req1 = 1'b0;
            @(negedge iCLK);
            if (c == 1) busy_first = busy1;
            if (mrd1 && mwr1) ovl++;
            if (mrd1) begin rdn++; rdc = c; end
            if (mwr1) begin wrn++; wrc = c; wd = mwdata1; end
            if (done1) begin
                dc = c; flt = fault1; ad = maddr1; rd = rdata1;
                break;
            end
        end
        if (dc != 0) begin
            @(negedge iCLK);
            busy_after = busy1;
        end
        if (!e.we && !e.fault) model_rdata = e.rdata;
        check32($sformatf("v%0d done_cycle", idx), 32'(dc), 32'(e.done_cyc));
        check32($sformatf("v%0d fault", idx), {31'h0, flt}, {31'h0, e.fault});
        check32($sformatf("v%0d read_count", idx), 32'(rdn), (e.rd_cyc != 0) ? 32'd1 : 32'd0);
        check32($sformatf("v%0d read_cycle", idx), 32'(rdc), 32'(e.rd_cyc));
        check32($sformatf("v%0d write_count", idx), 32'(wrn), (e.wr_cyc != 0) ? 32'd1 : 32'd0);
        check32($sformatf("v%0d write_cycle", idx), 32'(wrc), 32'(e.wr_cyc));
        if (e.wr_cyc != 0) check32($sformatf("v%0d write_data", idx), wd, e.wr_data);
        check32($sformatf("v%0d rdata", idx), rd, model_rdata);
        if (!e.fault) check32($sformatf("v%0d mem_addr", idx), ad, {e.addr[31:2], 2'b00});
        check32($sformatf("v%0d strobe_overlap", idx), 32'(ovl), 32'd0);
        check32($sformatf("v%0d busy_at_1", idx), {31'h0, busy_first}, 32'd1);
        check32($sformatf("v%0d busy_after_done", idx), {31'h0, busy_after}, 32'd0);
    endtask

    initial begin
        int          rdn, wrn, dn, rdc, dc;
        logic [31:0] rd;

        //          we    f3      addr           wdata          mem            flt   rdata         rd wr dn wr_data
        vecs[0]  = '{1'b0, 3'b010, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1, 0, 3, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h1000_0003, 32'h0,         32'h80FF_FFFF, 1'b0, 32'hFFFF_FF80, 1, 0, 3, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h1000_0003, 32'h0,         32'h80FF_FFFF, 1'b0, 32'h0000_0080, 1, 0, 3, 32'h0};
        vecs[3]  = '{1'b0, 3'b101, 32'h1000_0002, 32'h0,         32'h80FF_FFFF, 1'b0, 32'h0000_80FF, 1, 0, 3, 32'h0};
        vecs[4]  = '{1'b0, 3'b001, 32'h1000_0002, 32'h0,         32'h80FF_FFFF, 1'b0, 32'hFFFF_80FF, 1, 0, 3, 32'h0};
        vecs[5]  = '{1'b0, 3'b001, 32'h1000_0000, 32'h0,         32'h1234_8765, 1'b0, 32'hFFFF_8765, 1, 0, 3, 32'h0};
        vecs[6]  = '{1'b1, 3'b000, 32'h1000_0001, 32'hFFFF_FFAB, 32'h1122_3344, 1'b0, 32'h0,         1, 3, 4, 32'h1122_AB44};
        vecs[7]  = '{1'b1, 3'b001, 32'h1000_0002, 32'h0000_CAFE, 32'h1122_3344, 1'b0, 32'h0,         1, 3, 4, 32'hCAFE_3344};
        vecs[8]  = '{1'b1, 3'b010, 32'h1000_0008, 32'h5555_AAAA, 32'h0,         1'b0, 32'h0,         0, 1, 2, 32'h5555_AAAA};
        vecs[9]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'h0,         1'b1, 32'h0,         0, 0, 1, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'h1000_0001, 32'h0,         32'h0,         1'b1, 32'h0,         0, 0, 1, 32'h0};
        vecs[11] = '{1'b0, 3'b010, 32'h1000_0002, 32'h0,         32'h0,         1'b1, 32'h0,         0, 0, 1, 32'h0};
        vecs[12] = '{1'b0, 3'b011, 32'h1000_0000, 32'h0,         32'h0,         1'b1, 32'h0,         0, 0, 1, 32'h0};
        vecs[13] = '{1'b1, 3'b100, 32'h1000_0000, 32'h0,         32'h0,         1'b1, 32'h0,         0, 0, 1, 32'h0};
        vecs[14] = '{1'b0, 3'b101, 32'h1000_0003, 32'h0,         32'h0,         1'b1, 32'h0,         0, 0, 1, 32'h0};
        vecs[15] = '{1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'h0102_0304, 1'b0, 32'h0102_0304, 1, 0, 3, 32'h0};
        vecs[16] = '{1'b1, 3'b000, 32'h1000_0003, 32'h0000_0011, 32'hAABB_CCDD, 1'b0, 32'h0,         1, 3, 4, 32'h11BB_CCDD};
        vecs[17] = '{1'b0, 3'b000, 32'h1000_0001, 32'h0,         32'h0000_7F00, 1'b0, 32'h0000_007F, 1, 0, 3, 32'h0};

        iRSTn = 1'b0;
        req1 = 1'b0; we1 = 1'b0; f3_1 = 3'b000; addr1 = 32'h0; wdata1 = 32'h0; mem_word1 = 32'h0;
        req3 = 1'b0; we3 = 1'b0; f3_3 = 3'b000; addr3 = 32'h0; wdata3 = 32'h0; mem_word3 = 32'h0;

        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        check32("reset flags", {27'h0, busy1, done1, fault1, mrd1, mwr1}, 32'h0);
        check32("reset rdata", rdata1, 32'h0);
        check32("reset mem_addr", maddr1, 32'h0);
        check32("reset mem_wdata", mwdata1, 32'h0);
        check32("reset flags lat3", {27'h0, busy3, done3, fault3, mrd3, mwr3}, 32'h0);
        @(posedge iCLK);
        #1;
        iRSTn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // RD_LAT=3 load with a second request pulsed while busy
        @(posedge iCLK);
        #1;
        req3 = 1'b1; we3 = 1'b0; f3_3 = 3'b010; addr3 = 32'h1000_0004; mem_word3 = 32'hCAFE_F00D;
        n_vec++;
        rdn = 0; wrn = 0; dn = 0; rdc = 0; dc = 0; rd = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge iCLK);
            #1;
            if (c == 1) req3 = 1'b0;
            if (c == 2) begin
                req3 = 1'b1; we3 = 1'b1; f3_3 = 3'b010; addr3 = 32'h1000_0100; wdata3 = 32'h7777_7777;
            end
            if (c == 3) req3 = 1'b0;
            @(negedge iCLK);
            if (mrd3) begin rdn++; rdc = c; end
            if (mwr3) wrn++;
            if (done3) begin dn++; dc = c; rd = rdata3; end
        end
        check32("lat3 done_count", 32'(dn), 32'd1);
        check32("lat3 done_cycle", 32'(dc), 32'd5);
        check32("lat3 read_count", 32'(rdn), 32'd1);
        check32("lat3 read_cycle", 32'(rdc), 32'd1);
        check32("lat3 write_count", 32'(wrn), 32'd0);
        check32("lat3 rdata", rd, 32'hCAFE_F00D);

        // Reset while an SH sits in WAIT: the write must never be issued
        @(posedge iCLK);
        #1;
        req1 = 1'b1; we1 = 1'b1; f3_1 = 3'b001; addr1 = 32'h1000_0002; wdata1 = 32'h0000_1234;
        mem_word1 = 32'h5566_7788;
        n_vec++;
        @(posedge iCLK);
        #1;
        req1 = 1'b0;
        @(posedge iCLK);
        #1;
        iRSTn = 1'b0;
        @(negedge iCLK);
        check32("rst_wait busy_before", {31'h0, busy1}, 32'd1);
        @(posedge iCLK);
        #1;
        iRSTn = 1'b1;
        @(negedge iCLK);
        check32("rst_wait flags", {27'h0, busy1, done1, fault1, mrd1, mwr1}, 32'h0);
        check32("rst_wait rdata", rdata1, 32'h0);
        check32("rst_wait mem_addr", maddr1, 32'h0);
        check32("rst_wait mem_wdata", mwdata1, 32'h0);
        wrn = 0; dn = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge iCLK);
            if (mwr1) wrn++;
            if (done1) dn++;
        end
        check32("rst_wait late_write", 32'(wrn), 32'd0);
        check32("rst_wait late_done", 32'(dn), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
